// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with grant hold, hold limit and registered one-hot/encoded grant.
// The rotation pointer advances only after a grant ends, so the client just served drops to lowest priority.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state_r,    state_s;
   logic [1:0]        ptr_r,      ptr_s;
   logic [1:0]        owner_r,    owner_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
   logic [3:0]        gnt_r,      gnt_s;
   logic [1:0]        idx_r,      idx_s;
   logic              valid_r,    valid_s;
   logic              timeout_r,  timeout_s;
   logic [1:0]        winner_s;

   function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] cand;
      logic       found;
      w     = p;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand  = p + 2'(i);
         w     = (!found && r[cand]) ? cand : w;
         found = found | r[cand];
      end
      return w;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   assign winner_s = pick_winner(req, ptr_r);

   // Next-state and next-output logic for the arbitration FSM.
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      owner_s    = owner_r;
      hold_cnt_s = hold_cnt_r;
      gnt_s      = gnt_r;
      idx_s      = idx_r;
      valid_s    = valid_r;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (en && (req != 4'b0000)) begin
               state_s    = GRANT;
               owner_s    = winner_s;
               gnt_s      = onehot(winner_s);
               idx_s      = winner_s;
               valid_s    = 1'b1;
               hold_cnt_s = '0;
            end else begin
               gnt_s   = 4'b0000;
               idx_s   = 2'b00;
               valid_s = 1'b0;
            end
         end
         GRANT: begin
            // Disable and request drop outrank the hold limit, so they never flag a timeout.
            if (!en || !req[owner_r]) begin
               state_s = RELEASE;
               gnt_s   = 4'b0000;
               idx_s   = 2'b00;
               valid_s = 1'b0;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_s   = RELEASE;
               gnt_s     = 4'b0000;
               idx_s     = 2'b00;
               valid_s   = 1'b0;
               timeout_s = 1'b1;
            end else begin
               hold_cnt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         RELEASE: begin
            state_s = IDLE;
            ptr_s   = owner_r + 2'd1;
            gnt_s   = 4'b0000;
            idx_s   = 2'b00;
            valid_s = 1'b0;
         end
         default: begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            idx_s   = 2'b00;
            valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ptr_r      <= 2'd0;
         owner_r    <= 2'd0;
         hold_cnt_r <= '0;
         gnt_r      <= 4'b0000;
         idx_r      <= 2'b00;
         valid_r    <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         owner_r    <= owner_s;
         hold_cnt_r <= hold_cnt_s;
         gnt_r      <= gnt_s;
         idx_r      <= idx_s;
         valid_r    <= valid_s;
         timeout_r  <= timeout_s;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_idx   = idx_r;
   assign gnt_valid = valid_r;
   assign timeout   = timeout_r;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource, such as the 4:2 encoder datapath, between four clients. It produces a one-hot grant vector, its 2-bit encoded index (same bit mapping as the 4:2 encoder), and a valid flag. Grants are held while the owner keeps requesting, and are bounded by a hold limit so no client can starve the others. It sits between the request sources and the shared encoder/resource and is fully registered.

## Interface
- MAX_HOLD, 15: maximum consecutive cycles one owner may hold the grant (legal range 1..2^HOLD_W-1).
- HOLD_W, 4: width of the internal hold counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; the only clock is clk.
- en  input  1  arbiter enable; when low, no new grant is issued and any current grant is released.
- req  input  4  level request per client; bit i is client i.
- gnt  output  4  one-hot grant, registered; 0000 when no owner.
- gnt_idx  output  2  encoded owner index, registered (0001→00, 0010→01, 0100→10, 1000→11); 00 when no owner.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

## Operation
- State: `IDLE`, `GRANT`, `RELEASE`. Also `ptr` (2 bits, highest-priority client) and `owner` (2 bits), plus `hold_cnt` (HOLD_W bits).
- Reset (async, rst_n=0):
  - state=`IDLE`, ptr=0, hold_cnt=0.
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, all cleared immediately, without waiting for a clock edge.
- `IDLE` → `GRANT` when en=1 and req≠0000.
  - The winner is the first set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that edge, owner=winner, gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Otherwise the arbiter stays in `IDLE` with outputs zero.
- `GRANT`, evaluated each edge in priority order:
  1. en=0 → `RELEASE`, timeout=0.
  2. req[owner]=0 → `RELEASE`, timeout=0.
  3. hold_cnt=MAX_HOLD-1 → `RELEASE`, timeout=1 for one cycle.
  4. Else stay in `GRANT` and increment hold_cnt. Requests from other clients do not preempt.
- On the transition into `RELEASE`, gnt/gnt_idx/gnt_valid clear.
- `RELEASE` lasts one cycle.
  - ptr=owner+1 (mod 4, so 3 wraps to 0), timeout returns to 0, then → `IDLE`.
- The rotation is updated only in `RELEASE`, so the just-served client becomes lowest priority.
- gnt, gnt_idx and gnt_valid are always mutually consistent. gnt never has more than one bit set.

## Timing
- Grant latency: req sampled high in `IDLE` at edge k means gnt is valid after edge k (one registered stage).
- Hold length: gnt is high for at most MAX_HOLD cycles; it is exactly MAX_HOLD cycles when req[owner] and en stay high (timeout case).
- Release latency: when req[owner] drops and is sampled low at edge k, gnt is 0 after edge k.
- Inter-grant gap: 2 cycles with gnt=0000 (`RELEASE` + `IDLE` sample) between consecutive grants.
- timeout is high only in the first cycle of `RELEASE`.
- Simultaneous events:
  - en=0 together with timeout condition: release with timeout=0.
  - req[owner] drop together with hold limit: release with timeout=0.
- Requests that change during `RELEASE` are ignored until `IDLE`.
- Reset mid-grant: outputs clear asynchronously. After rst_n rises, arbitration restarts with ptr=0.

## Test plan
- Reset: hold rst_n=0 with req=1111, en=1 → gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0. Release reset → first grant gnt=0001, idx=00.
- Single request: en=1, req=0100 for 3 cycles then 0000 → gnt=0100, idx=10, valid=1 for 3 cycles. Grant starts one cycle after req, and gnt=0000 one cycle after req drops.
- Round robin with timeout: MAX_HOLD=4, en=1, req=1111 held → owners 0,1,2,3,0 (idx 00,01,10,11,00), each for 4 cycles. A timeout pulse follows each grant, with a 2-cycle gap of gnt=0000.
- Enable control:
  - en=0, req=0010 → no grant.
  - Raise en → gnt=0010.
  - Drop en mid-grant → gnt=0000 next cycle, timeout stays 0.
- Pointer wrap: client 3 owns then releases, next req=1001 → gnt=0001 (client 0 wins over 3).
- Reset mid-grant: while gnt=1000, pulse rst_n low between edges → gnt=0000 immediately. After reset, req=1010 → gnt=0010.
